// File: rtl/time_of_day_pkg.sv
// rtl/time_of_day_pkg.sv - shared BCD widths, constants and validity helper for time_of_day_counter
//
// Purpose: common types and constants for the time-of-day counter slice.
//   BCD_DIGIT_W / BCD_PAIR_W : width of one BCD digit / a {tens,units} pair
//   BCD_ZERO                 : cleared pair value
//   HOUR_MAX_DEF / MINSEC_MAX_DEF : default wrap points for a 24 h clock
//   bcd_pair_valid()         : true when both nibbles are decimal digits and the
//                              pair's value does not exceed the given maximum

package time_of_day_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_PAIR_W  = 2 * BCD_DIGIT_W;

  localparam logic [BCD_PAIR_W-1:0]  BCD_ZERO      = 8'h00;
  localparam logic [BCD_DIGIT_W-1:0] BCD_DIGIT_MAX = 4'd9;

  localparam int HOUR_MAX_DEF   = 23;
  localparam int MINSEC_MAX_DEF = 59;

  typedef logic [BCD_PAIR_W-1:0] bcd_pair_t;

  typedef struct packed {
    bcd_pair_t hh;
    bcd_pair_t mm;
    bcd_pair_t ss;
  } tod_t;

  function automatic logic bcd_pair_valid(input bcd_pair_t pair, input int max_val);
    int tens;
    int units;
    tens  = int'(pair[BCD_PAIR_W-1:BCD_DIGIT_W]);
    units = int'(pair[BCD_DIGIT_W-1:0]);
    return (pair[BCD_PAIR_W-1:BCD_DIGIT_W] <= BCD_DIGIT_MAX) &&
           (pair[BCD_DIGIT_W-1:0] <= BCD_DIGIT_MAX) &&
           ((tens * 10 + units) <= max_val);
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - two-digit BCD modulo-(MAX+1) counter stage with carry
//
// Purpose: one {tens,units} BCD field of the clock (seconds, minutes or hours).
//   Counts 00..MAX in BCD, wraps to 00 and raises carry in the same cycle as
//   the increment so the next stage can advance in that same clock edge.
// Parameters:
//   MAX        last value before wrap (decimal, e.g. 59 or 23)
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset, clears value and wrap_tick
//   inc        advance by one this cycle
//   load       replace value with load_val this cycle (overrides inc)
//   load_val   BCD pair to load; the caller guarantees it is in range
//   value      registered current BCD pair
//   carry      combinational: this cycle's inc wraps MAX->00 (chains to next stage)
//   wrap_tick  registered one-cycle strobe aligned with the wrapped value
//   value_nxt  (ALARM_EN only) value that will be registered at the next edge

module bcd_mod_counter
  import time_of_day_pkg::*;
#(
  parameter int MAX = MINSEC_MAX_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc,
  input  logic                  load,
  input  logic [BCD_PAIR_W-1:0] load_val,
`ifdef ALARM_EN
  output logic [BCD_PAIR_W-1:0] value_nxt,
`endif
  output logic [BCD_PAIR_W-1:0] value,
  output logic                  carry,
  output logic                  wrap_tick
);

  localparam logic [BCD_DIGIT_W-1:0] MAX_TENS  = BCD_DIGIT_W'(MAX / 10);
  localparam logic [BCD_DIGIT_W-1:0] MAX_UNITS = BCD_DIGIT_W'(MAX % 10);
  localparam logic [BCD_PAIR_W-1:0]  MAX_BCD   = {MAX_TENS, MAX_UNITS};

  logic [BCD_DIGIT_W-1:0] tens;
  logic [BCD_DIGIT_W-1:0] units;
  logic                   at_max;
  logic [BCD_PAIR_W-1:0]  next_val;

  assign tens   = value[BCD_PAIR_W-1:BCD_DIGIT_W];
  assign units  = value[BCD_DIGIT_W-1:0];
  assign at_max = (value == MAX_BCD);

  // A load in the same cycle suppresses the wrap so no strobe leaks out.
  assign carry = inc & ~load & at_max;

  always_comb begin
    next_val = value;
    if (load) begin
      next_val = load_val;
    end else if (inc) begin
      if (at_max) begin
        next_val = BCD_ZERO;
      end else if (units == BCD_DIGIT_MAX) begin
        next_val = {tens + 4'd1, 4'd0};
      end else begin
        next_val = {tens, units + 4'd1};
      end
    end
  end

`ifdef ALARM_EN
  assign value_nxt = next_val;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value     <= BCD_ZERO;
      wrap_tick <= 1'b0;
    end else begin
      value     <= next_val;
      wrap_tick <= carry;
    end
  end

endmodule

// File: rtl/time_of_day_counter.sv
// rtl/time_of_day_counter.sv - 24 h BCD HH:MM:SS wall clock driven by a 1 Hz tick
//
// Purpose: counts sec_pulse ticks into packed BCD hours/minutes/seconds with
//   synchronous load, pause (run_en) and one-cycle rollover strobes.
//   Optional alarm compare is built when the ALARM_EN macro is defined.
// Parameters:
//   HOUR_MAX    last hour before wrap to 00 (23 => 24 h clock)
//   MINSEC_MAX  last minute/second before wrap
// Ports:
//   clk, rst_n             system clock, asynchronous active-low reset
//   sec_pulse              one-cycle tick; every high cycle is one second
//   run_en                 1 = count ticks, 0 = ignore them
//   load, load_hh/mm/ss    one-cycle time load request and BCD values
//   hh_bcd, mm_bcd, ss_bcd registered current time
//   min_tick, hour_tick, day_tick  one-cycle rollover strobes
//   load_err               one-cycle strobe: rejected load / alarm set
//   alarm_set, alarm_arm, alarm_hit  (ALARM_EN only) alarm capture, arm level,
//                          one-cycle hit when time becomes alarm_hh:alarm_mm:00

module time_of_day_counter
  import time_of_day_pkg::*;
#(
  parameter int HOUR_MAX   = HOUR_MAX_DEF,
  parameter int MINSEC_MAX = MINSEC_MAX_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sec_pulse,
  input  logic                  run_en,
  input  logic                  load,
  input  logic [BCD_PAIR_W-1:0] load_hh,
  input  logic [BCD_PAIR_W-1:0] load_mm,
  input  logic [BCD_PAIR_W-1:0] load_ss,
`ifdef ALARM_EN
  input  logic                  alarm_set,
  input  logic                  alarm_arm,
  output logic                  alarm_hit,
`endif
  output logic [BCD_PAIR_W-1:0] hh_bcd,
  output logic [BCD_PAIR_W-1:0] mm_bcd,
  output logic [BCD_PAIR_W-1:0] ss_bcd,
  output logic                  min_tick,
  output logic                  hour_tick,
  output logic                  day_tick,
  output logic                  load_err
);

  logic time_valid;
  logic load_ok;
  logic advance;
  logic err_req;
  logic ss_carry;
  logic mm_carry;
  logic hh_carry;

  assign time_valid = bcd_pair_valid(load_hh, HOUR_MAX) &&
                      bcd_pair_valid(load_mm, MINSEC_MAX) &&
                      bcd_pair_valid(load_ss, MINSEC_MAX);

  // Any load request, valid or not, swallows a coincident tick.
  assign load_ok = load & time_valid;
  assign advance = sec_pulse & run_en & ~load;

`ifdef ALARM_EN
  logic [BCD_PAIR_W-1:0] hh_nxt;
  logic [BCD_PAIR_W-1:0] mm_nxt;
  logic [BCD_PAIR_W-1:0] ss_nxt;
`endif

  bcd_mod_counter #(.MAX(MINSEC_MAX)) u_ss (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (advance),
    .load      (load_ok),
    .load_val  (load_ss),
`ifdef ALARM_EN
    .value_nxt (ss_nxt),
`endif
    .value     (ss_bcd),
    .carry     (ss_carry),
    .wrap_tick (min_tick)
  );

  bcd_mod_counter #(.MAX(MINSEC_MAX)) u_mm (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (ss_carry),
    .load      (load_ok),
    .load_val  (load_mm),
`ifdef ALARM_EN
    .value_nxt (mm_nxt),
`endif
    .value     (mm_bcd),
    .carry     (mm_carry),
    .wrap_tick (hour_tick)
  );

  bcd_mod_counter #(.MAX(HOUR_MAX)) u_hh (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (mm_carry),
    .load      (load_ok),
    .load_val  (load_hh),
`ifdef ALARM_EN
    .value_nxt (hh_nxt),
`endif
    .value     (hh_bcd),
    .carry     (hh_carry),
    .wrap_tick (day_tick)
  );

`ifdef ALARM_EN
  logic [BCD_PAIR_W-1:0] alarm_hh;
  logic [BCD_PAIR_W-1:0] alarm_mm;
  logic                  alarm_valid;
  logic                  alarm_match;

  assign alarm_valid = bcd_pair_valid(load_hh, HOUR_MAX) &&
                       bcd_pair_valid(load_mm, MINSEC_MAX);

  // Compare against the time about to be registered so the hit lines up
  // with the new time on the outputs.
  assign alarm_match = alarm_arm & (advance | load_ok) &
                       (hh_nxt == alarm_hh) & (mm_nxt == alarm_mm) &
                       (ss_nxt == BCD_ZERO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_hh  <= BCD_ZERO;
      alarm_mm  <= BCD_ZERO;
      alarm_hit <= 1'b0;
    end else begin
      alarm_hit <= alarm_match;
      if (alarm_set && alarm_valid) begin
        alarm_hh <= load_hh;
        alarm_mm <= load_mm;
      end
    end
  end
`endif

  always_comb begin
    err_req = load & ~time_valid;
`ifdef ALARM_EN
    err_req = err_req | (alarm_set & ~alarm_valid);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_err <= 1'b0;
    end else begin
      load_err <= err_req;
    end
  end

  // The hours carry has no further stage; day_tick comes from the counter's
  // own registered wrap strobe.
  logic unused_hh_carry;
  assign unused_hh_carry = hh_carry;

endmodule

// File: tb/tb_time_of_day_counter.sv
// tb/tb_time_of_day_counter.sv - self-checking bench for time_of_day_counter

module tb_time_of_day_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sec_pulse;
  logic       run_en;
  logic       load;
  logic [7:0] load_hh;
  logic [7:0] load_mm;
  logic [7:0] load_ss;
  logic [7:0] hh_bcd;
  logic [7:0] mm_bcd;
  logic [7:0] ss_bcd;
  logic       min_tick;
  logic       hour_tick;
  logic       day_tick;
  logic       load_err;
`ifdef ALARM_EN
  logic       alarm_set;
  logic       alarm_arm;
  logic       alarm_hit;
  int         al_sec;
  logic       e_hit;
`endif

  int   errors = 0;
  int   checks = 0;
  int   tod    = 0;
  logic e_min, e_hour, e_day, e_err;

  always #5 clk = ~clk;

  time_of_day_counter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sec_pulse (sec_pulse),
    .run_en    (run_en),
    .load      (load),
    .load_hh   (load_hh),
    .load_mm   (load_mm),
    .load_ss   (load_ss),
`ifdef ALARM_EN
    .alarm_set (alarm_set),
    .alarm_arm (alarm_arm),
    .alarm_hit (alarm_hit),
`endif
    .hh_bcd    (hh_bcd),
    .mm_bcd    (mm_bcd),
    .ss_bcd    (ss_bcd),
    .min_tick  (min_tick),
    .hour_tick (hour_tick),
    .day_tick  (day_tick),
    .load_err  (load_err)
  );

  function automatic bit bcd_ok(input logic [7:0] p, input int mx);
    int t;
    int u;
    t = int'(p[7:4]);
    u = int'(p[3:0]);
    return (t <= 9) && (u <= 9) && (t * 10 + u <= mx);
  endfunction

  function automatic int bcd2int(input logic [7:0] p);
    return int'(p[7:4]) * 10 + int'(p[3:0]);
  endfunction

  function automatic logic [7:0] int2bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " hh"}, hh_bcd, int2bcd(tod / 3600));
    check({tag, " mm"}, mm_bcd, int2bcd((tod / 60) % 60));
    check({tag, " ss"}, ss_bcd, int2bcd(tod % 60));
    check({tag, " min_tick"},  {7'd0, min_tick},  {7'd0, e_min});
    check({tag, " hour_tick"}, {7'd0, hour_tick}, {7'd0, e_hour});
    check({tag, " day_tick"},  {7'd0, day_tick},  {7'd0, e_day});
    check({tag, " load_err"},  {7'd0, load_err},  {7'd0, e_err});
`ifdef ALARM_EN
    check({tag, " alarm_hit"}, {7'd0, alarm_hit}, {7'd0, e_hit});
`endif
  endtask

  // One clock: drive at the falling edge, check just after the rising edge.
  task automatic step(input string tag, input bit sp, input bit run, input bit ld,
                      input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    bit changed;
    @(negedge clk);
    sec_pulse = sp;
    run_en    = run;
    load      = ld;
    load_hh   = h;
    load_mm   = m;
    load_ss   = s;
    @(posedge clk);
    #1;
    e_min   = 1'b0;
    e_hour  = 1'b0;
    e_day   = 1'b0;
    e_err   = 1'b0;
    changed = 1'b0;
    if (ld) begin
      if (bcd_ok(h, 23) && bcd_ok(m, 59) && bcd_ok(s, 59)) begin
        tod     = bcd2int(h) * 3600 + bcd2int(m) * 60 + bcd2int(s);
        changed = 1'b1;
      end else begin
        e_err = 1'b1;
      end
    end else if (sp && run) begin
      tod     = (tod + 1) % 86400;
      changed = 1'b1;
      e_min   = (tod % 60 == 0);
      e_hour  = (tod % 3600 == 0);
      e_day   = (tod == 0);
    end
`ifdef ALARM_EN
    e_hit = alarm_arm && changed && (tod == al_sec);
    if (alarm_set) begin
      if (bcd_ok(h, 23) && bcd_ok(m, 59)) al_sec = bcd2int(h) * 3600 + bcd2int(m) * 60;
      else e_err = 1'b1;
    end
`endif
    check_all(tag);
  endtask

  initial begin
    logic [7:0] rh, rm, rs;
    bit         rsp, rrun, rld;
    rst_n     = 1'b0;
    sec_pulse = 1'b0;
    run_en    = 1'b0;
    load      = 1'b0;
    load_hh   = 8'h00;
    load_mm   = 8'h00;
    load_ss   = 8'h00;
    e_min = 0; e_hour = 0; e_day = 0; e_err = 0;
`ifdef ALARM_EN
    alarm_set = 1'b0;
    alarm_arm = 1'b0;
    al_sec    = 0;
    e_hit     = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Three ticks from reset, idle cycles between.
    for (int i = 0; i < 3; i++) begin
      step("tick", 1, 1, 0, 8'h00, 8'h00, 8'h00);
      step("idle", 0, 1, 0, 8'h00, 8'h00, 8'h00);
    end

    // Full rollover at end of day, strobes for exactly one cycle.
    step("load_eod", 0, 1, 1, 8'h23, 8'h59, 8'h59);
    step("rollover", 1, 1, 0, 8'h00, 8'h00, 8'h00);
    step("after_roll", 0, 1, 0, 8'h00, 8'h00, 8'h00);

    // Minute-only and hour-only carries.
    step("load_mc", 0, 1, 1, 8'h10, 8'h14, 8'h59);
    step("min_carry", 1, 1, 0, 8'h00, 8'h00, 8'h00);
    step("load_hc", 0, 1, 1, 8'h09, 8'h59, 8'h59);
    step("hour_carry", 1, 1, 0, 8'h00, 8'h00, 8'h00);

    // Invalid loads leave time untouched.
    step("bad_hh", 0, 1, 1, 8'h24, 8'h00, 8'h00);
    step("bad_mm", 1, 1, 1, 8'h01, 8'h5A, 8'h00);
    step("bad_ss", 0, 1, 1, 8'h01, 8'h00, 8'h60);
    step("after_bad", 0, 1, 0, 8'h00, 8'h00, 8'h00);

    // Load coincident with a tick: load wins, tick dropped.
    step("load_tick", 1, 1, 1, 8'h12, 8'h34, 8'h56);
    step("after_lt", 0, 1, 0, 8'h00, 8'h00, 8'h00);

    // Paused: ticks ignored, load still honoured; then one counted tick.
    for (int i = 0; i < 5; i++) step("paused", 1, 0, 0, 8'h00, 8'h00, 8'h00);
    step("paused_load", 0, 0, 1, 8'h05, 8'h06, 8'h07);
    step("resume", 1, 1, 0, 8'h00, 8'h00, 8'h00);

    // Back-to-back high cycles each count.
    for (int i = 0; i < 4; i++) step("burst", 1, 1, 0, 8'h00, 8'h00, 8'h00);

    // Reset in the middle of a rollover strobe clears everything at once.
    step("load_mid", 0, 1, 1, 8'h23, 8'h59, 8'h59);
    step("mid_roll", 1, 1, 0, 8'h00, 8'h00, 8'h00);
    #1;
    rst_n = 1'b0;
    #1;
    tod = 0; e_min = 0; e_hour = 0; e_day = 0; e_err = 0;
`ifdef ALARM_EN
    e_hit = 0; al_sec = 0;
`endif
    check_all("async_rst");
    @(negedge clk);
    sec_pulse = 1'b0;
    rst_n     = 1'b1;
    step("post_rst", 0, 1, 0, 8'h00, 8'h00, 8'h00);

`ifdef ALARM_EN
    alarm_set = 1'b1;
    step("alarm_set", 0, 1, 0, 8'h07, 8'h30, 8'h00);
    alarm_set = 1'b0;
    alarm_arm = 1'b1;
    step("al_load", 0, 1, 1, 8'h07, 8'h29, 8'h59);
    step("al_tick", 1, 1, 0, 8'h00, 8'h00, 8'h00);
    step("al_after", 0, 1, 0, 8'h00, 8'h00, 8'h00);
    alarm_arm = 1'b0;
    step("al_reload", 0, 1, 1, 8'h07, 8'h29, 8'h59);
    step("al_disarm", 1, 1, 0, 8'h00, 8'h00, 8'h00);
    alarm_set = 1'b1;
    step("al_bad", 0, 1, 0, 8'h25, 8'h00, 8'h00);
    alarm_set = 1'b0;
`endif

    // Randomized traffic, with loads near boundaries and occasional garbage.
    for (int i = 0; i < 600; i++) begin
      rsp  = ($urandom % 4) != 0;
      rrun = ($urandom % 5) != 0;
      rld  = ($urandom % 20) == 0;
      if (($urandom % 5) == 0) begin
        rh = 8'($urandom);
        rm = 8'($urandom);
        rs = 8'($urandom);
      end else begin
        rh = int2bcd(($urandom % 2) ? 23 : int'($urandom_range(0, 23)));
        rm = int2bcd(($urandom % 2) ? 59 : int'($urandom_range(0, 59)));
        rs = int2bcd(int'($urandom_range(50, 59)));
      end
      step("random", rsp, rrun, rld, rh, rm, rs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
